// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and writeback
// over one shared memory port. Control lines decode combinationally from state, IR, status and mem_ready.
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         inst,
    input  logic [3:0]          status,
    input  logic                mem_ready,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic                read,
    output logic                write,
    output logic [1:0]          MemtoReg,
    output logic [ALU_OP_W-1:0] ALU_operation,
    output logic [2:0]          immselect,
    output logic                retire,
    output logic                illegal,
    output logic                fault
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t      state_q;
    logic [31:0] ir_q;
    logic [7:0]  cnt_q;
    logic        illegal_q;
    logic        fault_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic       opc_legal;
    logic       br_f3_bad;
    logic       br_taken;
    logic       wait_expired;
    logic [3:0] alu_op;
    logic       unused_ir;

    assign opcode   = ir_q[6:0];
    assign funct3   = ir_q[14:12];
    assign unused_ir = ^{ir_q[31], ir_q[29:15], ir_q[11:7]};

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_lui   = (opcode == OP_LUI);
    assign is_auipc = (opcode == OP_AUIPC);

    assign opc_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc;
    assign br_f3_bad = is_br && (funct3[2:1] == 2'b01);

    // status: [0]=Z, [1]=N, [2]=LTU, [3]=V
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = status[0];
            3'b001:  br_taken = !status[0];
            3'b100:  br_taken = status[1] ^ status[3];
            3'b101:  br_taken = !(status[1] ^ status[3]);
            3'b110:  br_taken = status[2];
            3'b111:  br_taken = !status[2];
            default: br_taken = 1'b0;
        endcase
    end

    // A ready on the expiring cycle wins, so the caller always checks mem_ready first.
    assign wait_expired = (cnt_q + 8'd1) >= TMO;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= inst;
                        cnt_q   <= '0;
                        state_q <= DECODE;
                    end else if (wait_expired) begin
                        fault_q <= 1'b1;
                        state_q <= TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DECODE: begin
                    if (!opc_legal || br_f3_bad) begin
                        illegal_q <= 1'b1;
                        state_q   <= TRAP;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q <= '0;
                    if (is_br)
                        state_q <= FETCH;
                    else if (is_ld || is_st)
                        state_q <= MEM;
                    else
                        state_q <= WB;
                end
                MEM: begin
                    if (mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= is_ld ? WB : FETCH;
                    end else if (wait_expired) begin
                        fault_q <= 1'b1;
                        state_q <= TRAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WB: begin
                    cnt_q   <= '0;
                    state_q <= FETCH;
                end
                default: state_q <= TRAP;
            endcase
        end
    end

    assign ALU_operation = ALU_OP_W'(alu_op);

    // Everything is forced low while reset is held so an aborted instruction cannot write.
    always_comb begin
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 2'b00;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        read      = 1'b0;
        write     = 1'b0;
        MemtoReg  = 2'b00;
        alu_op    = 4'b0000;
        immselect = 3'b000;
        retire    = 1'b0;
        illegal   = 1'b0;
        fault     = 1'b0;
        if (!reset) begin
            illegal = illegal_q;
            fault   = fault_q;
            case (state_q)
                FETCH: begin
                    read    = 1'b1;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                EXEC: begin
                    case (opcode)
                        OP_R: alu_op = {ir_q[30], funct3};
                        OP_I: begin
                            ALUSrc = 1'b1;
                            alu_op = {ir_q[30] && (funct3 == 3'b101), funct3};
                        end
                        OP_LD: ALUSrc = 1'b1;
                        OP_ST: begin
                            ALUSrc    = 1'b1;
                            immselect = 3'b001;
                        end
                        OP_BR: begin
                            alu_op    = 4'b1000;
                            immselect = 3'b010;
                            retire    = 1'b1;
                            if (br_taken) begin
                                PCWrite = 1'b1;
                                PCSrc   = 2'b01;
                            end
                        end
                        OP_JAL: begin
                            immselect = 3'b100;
                            PCWrite   = 1'b1;
                            PCSrc     = 2'b01;
                        end
                        OP_JALR: begin
                            ALUSrc  = 1'b1;
                            PCWrite = 1'b1;
                            PCSrc   = 2'b10;
                        end
                        OP_LUI: begin
                            alu_op    = 4'b1111;
                            immselect = 3'b011;
                        end
                        OP_AUIPC: immselect = 3'b011;
                        default: ;
                    endcase
                end
                MEM: begin
                    ALUSrc    = 1'b1;
                    immselect = is_st ? 3'b001 : 3'b000;
                    read      = is_ld;
                    write     = is_st;
                    retire    = is_st && mem_ready;
                end
                WB: begin
                    RegWrite = 1'b1;
                    retire   = 1'b1;
                    if (is_ld)
                        MemtoReg = 2'b01;
                    else if (is_jal || is_jalr)
                        MemtoReg = 2'b10;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, trap/timeout/reset sequences,
// and random instruction streams checked against a per-instruction expected-trace model.
module tb_multicycle_control_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst = '0;
    logic [3:0]  status = '0;
    logic        mem_ready = 1'b0;
    logic        IRWrite, PCWrite, RegWrite, ALUSrc, read, write, retire, illegal, fault;
    logic [1:0]  PCSrc, MemtoReg;
    logic [3:0]  ALU_operation;
    logic [2:0]  immselect;

    multicycle_control_unit #(.ALU_OP_W(4), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .inst(inst), .status(status), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite),
        .ALUSrc(ALUSrc), .read(read), .write(write), .MemtoReg(MemtoReg),
        .ALU_operation(ALU_operation), .immselect(immselect), .retire(retire),
        .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic       alusrc;
        logic       rd;
        logic       wr;
        logic [1:0] m2r;
        logic [3:0] aop;
        logic [2:0] imm;
        logic       retire;
        logic       ill;
        logic       flt;
    } outs_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  st;
        int          cyc;
        logic        pcw;
        logic [1:0]  pcsrc;
        logic [3:0]  aop;
        logic        alusrc;
        logic [2:0]  imm;
        logic [1:0]  m2r;
        logic        regw;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    outs_t got  [1:24];
    outs_t expv [1:24];
    vec_t  tbl  [16];
    logic [6:0] ops  [9];
    logic [2:0] bf3s [6];

    function automatic outs_t smp();
        return {IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, read, write, MemtoReg,
                ALU_operation, immselect, retire, illegal, fault};
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick(input logic mr, output outs_t o);
        mem_ready = mr;
        @(negedge clk);
        o = smp();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("reset_cycle_outputs", 32'(smp()), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drives one instruction: fw fetch wait cycles, mw mem wait cycles; stops at retire.
    task automatic run(input logic [31:0] ins, input logic [3:0] st, input int fw,
                       input int mw, input bit rnd, output int ncyc);
        ncyc = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= fw)
                mem_ready = 1'b0;
            else if (c == fw + 1)
                mem_ready = 1'b1;
            else if (c <= fw + 3)
                mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            else
                mem_ready = (c < fw + 4 + mw) ? 1'b0 : 1'b1;
            inst   = (c == fw + 1) ? ins : $urandom;
            status = st;
            @(negedge clk);
            got[c] = smp();
            @(posedge clk);
            #1;
            if (got[c].retire) begin
                ncyc = c;
                break;
            end
        end
    endtask

    // Expected output trace of one legal instruction, phase by phase; returns its length.
    function automatic int model(input logic [31:0] ins, input logic [3:0] st,
                                 input int fw, input int mw);
        int         n;
        outs_t      o;
        logic [6:0] opc;
        logic [2:0] f3;
        bit         z, ng, ltu, v, take;
        n = 0; opc = ins[6:0]; f3 = ins[14:12];
        z = st[0]; ng = st[1]; ltu = st[2]; v = st[3];
        for (int i = 0; i < fw; i++) begin
            o = '0; o.rd = 1'b1; n++; expv[n] = o;
        end
        o = '0; o.rd = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; n++; expv[n] = o;
        o = '0; n++; expv[n] = o;
        o = '0;
        case (opc)
            7'b0110011: o.aop = {ins[30], f3};
            7'b0010011: begin
                o.alusrc = 1'b1;
                o.aop = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
            end
            7'b0000011: o.alusrc = 1'b1;
            7'b0100011: begin o.alusrc = 1'b1; o.imm = 3'd1; end
            7'b1100011: begin
                o.aop = 4'd8; o.imm = 3'd2; o.retire = 1'b1;
                case (f3)
                    3'd0:    take = z;
                    3'd1:    take = !z;
                    3'd4:    take = (ng != v);
                    3'd5:    take = (ng == v);
                    3'd6:    take = ltu;
                    default: take = !ltu;
                endcase
                if (take) begin o.pcw = 1'b1; o.pcsrc = 2'd1; end
                n++; expv[n] = o;
                return n;
            end
            7'b1101111: begin o.imm = 3'd4; o.pcw = 1'b1; o.pcsrc = 2'd1; end
            7'b1100111: begin o.alusrc = 1'b1; o.pcw = 1'b1; o.pcsrc = 2'd2; end
            7'b0110111: begin o.aop = 4'd15; o.imm = 3'd3; end
            default:    o.imm = 3'd3;
        endcase
        n++; expv[n] = o;
        if (opc == 7'b0000011 || opc == 7'b0100011) begin
            o.rd = (opc == 7'b0000011);
            o.wr = (opc == 7'b0100011);
            for (int i = 0; i < mw; i++) begin n++; expv[n] = o; end
            if (o.wr) begin
                o.retire = 1'b1; n++; expv[n] = o;
                return n;
            end
            n++; expv[n] = o;
        end
        o = '0; o.regw = 1'b1; o.retire = 1'b1;
        o.m2r = (opc == 7'b0000011) ? 2'd1 :
                (opc == 7'b1101111 || opc == 7'b1100111) ? 2'd2 : 2'd0;
        n++; expv[n] = o;
        return n;
    endfunction

    task automatic illegal_seq(input string nm, input logic [31:0] ins);
        outs_t o, only_ill;
        only_ill = '0; only_ill.ill = 1'b1;
        do_reset();
        inst = ins;
        tick(1'b1, o);
        chk({nm, "_fetch_irw"}, 32'({o.irw, o.rd}), 32'b11);
        tick(1'b1, o);
        chk({nm, "_decode_quiet"}, 32'(o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, o);
            chk($sformatf("%s_trap%0d", nm, i), 32'(o), 32'(only_ill));
        end
        do_reset();
        tick(1'b0, o);
        chk({nm, "_cleared"}, 32'({o.ill, o.flt, o.rd}), 32'b001);
    endtask

    initial begin
        int    nc, n, nrd, nwr;
        outs_t o, only_flt;
        logic [31:0] ins;
        logic [3:0]  st;

        //         ins           st     cyc pcw pcsrc aop    src imm   m2r  regw
        tbl[0]  = '{32'h002081B3, 4'h0, 4, 1'b0, 2'd0, 4'h0, 1'b0, 3'd0, 2'd0, 1'b1}; // ADD
        tbl[1]  = '{32'h402081B3, 4'h0, 4, 1'b0, 2'd0, 4'h8, 1'b0, 3'd0, 2'd0, 1'b1}; // SUB
        tbl[2]  = '{32'h00209463, 4'h0, 3, 1'b1, 2'd1, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BNE Z=0
        tbl[3]  = '{32'h00209463, 4'h1, 3, 1'b0, 2'd0, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BNE Z=1
        tbl[4]  = '{32'h0020C463, 4'hA, 3, 1'b0, 2'd0, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BLT N=V=1
        tbl[5]  = '{32'h0020F463, 4'h0, 3, 1'b1, 2'd1, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BGEU LTU=0
        tbl[6]  = '{32'h0020E463, 4'h4, 3, 1'b1, 2'd1, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BLTU LTU=1
        tbl[7]  = '{32'h00208463, 4'h1, 3, 1'b1, 2'd1, 4'h8, 1'b0, 3'd2, 2'd0, 1'b0}; // BEQ Z=1
        tbl[8]  = '{32'h0000A183, 4'h0, 5, 1'b0, 2'd0, 4'h0, 1'b1, 3'd0, 2'd1, 1'b1}; // LW
        tbl[9]  = '{32'h0020A023, 4'h0, 4, 1'b0, 2'd0, 4'h0, 1'b1, 3'd1, 2'd0, 1'b0}; // SW
        tbl[10] = '{32'h000000EF, 4'h0, 4, 1'b1, 2'd1, 4'h0, 1'b0, 3'd4, 2'd2, 1'b1}; // JAL
        tbl[11] = '{32'h000100E7, 4'h0, 4, 1'b1, 2'd2, 4'h0, 1'b1, 3'd0, 2'd2, 1'b1}; // JALR
        tbl[12] = '{32'h123450B7, 4'h0, 4, 1'b0, 2'd0, 4'hF, 1'b0, 3'd3, 2'd0, 1'b1}; // LUI
        tbl[13] = '{32'h00001097, 4'h0, 4, 1'b0, 2'd0, 4'h0, 1'b0, 3'd3, 2'd0, 1'b1}; // AUIPC
        tbl[14] = '{32'h40315093, 4'h0, 4, 1'b0, 2'd0, 4'hD, 1'b1, 3'd0, 2'd0, 1'b1}; // SRAI
        tbl[15] = '{32'h40010093, 4'h0, 4, 1'b0, 2'd0, 4'h0, 1'b1, 3'd0, 2'd0, 1'b1}; // ADDI imm[10]=1

        ops  = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bf3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            run(tbl[i].ins, tbl[i].st, 0, 0, 1'b0, nc);
            chk($sformatf("vec%0d_cycles", i), 32'(nc), 32'(tbl[i].cyc));
            chk($sformatf("vec%0d_exec", i),
                32'({got[3].pcw, got[3].pcsrc, got[3].aop, got[3].alusrc, got[3].imm}),
                32'({tbl[i].pcw, tbl[i].pcsrc, tbl[i].aop, tbl[i].alusrc, tbl[i].imm}));
            n = (nc > 0) ? nc : 1;
            chk($sformatf("vec%0d_last", i), 32'({got[n].m2r, got[n].regw}),
                32'({tbl[i].m2r, tbl[i].regw}));
        end

        // LW with three wait-states in MEM
        run(32'h0000A183, 4'h0, 0, 3, 1'b0, nc);
        chk("lw_wait_cycles", 32'(nc), 32'd8);
        nrd = 0; nwr = 0;
        for (int c = 4; c <= 7; c++) begin
            nrd += int'(got[c].rd);
            nwr += int'(got[c].wr);
        end
        chk("lw_wait_reads", 32'(nrd), 32'd4);
        chk("lw_wait_writes", 32'(nwr), 32'd0);
        chk("lw_wait_wb", 32'({got[8].m2r, got[8].regw, got[8].retire}), 32'b0111);

        for (int k = 0; k < 150; k++) begin
            int fw, mw;
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 8)];
            if (ins[6:0] == 7'b1100011)
                ins[14:12] = bf3s[$urandom_range(0, 5)];
            st = 4'($urandom);
            fw = $urandom_range(0, TMO - 1);
            mw = $urandom_range(0, TMO - 1);
            n = model(ins, st, fw, mw);
            run(ins, st, fw, mw, 1'b1, nc);
            chk($sformatf("rand%0d_cycles ins=%h", k, ins), 32'(nc), 32'(n));
            for (int c = 1; c <= n; c++)
                chk($sformatf("rand%0d_c%0d ins=%h", k, c, ins), 32'(got[c]), 32'(expv[c]));
        end

        // Reset asserted during WB of an ADD suppresses RegWrite
        do_reset();
        inst = 32'h002081B3;
        for (int c = 0; c < 3; c++) tick(1'b1, o);
        reset = 1'b1;
        tick(1'b1, o);
        chk("reset_in_wb_outputs", 32'(o), 32'd0);
        reset = 1'b0;
        tick(1'b0, o);
        chk("reset_in_wb_refetch", 32'({o.rd, o.regw, o.retire}), 32'b100);

        illegal_seq("bad_opcode", 32'h0000007F);
        illegal_seq("bad_branch_f3", 32'h0020A463);

        // Fetch timeout: no mem_ready at all
        only_flt = '0; only_flt.flt = 1'b1;
        do_reset();
        nrd = 0;
        for (int c = 0; c < TMO; c++) begin
            tick(1'b0, o);
            nrd += int'(o.rd);
            chk($sformatf("fetch_wait%0d_nofault", c), 32'(o.flt), 32'd0);
        end
        chk("fetch_wait_reads", 32'(nrd), 32'(TMO));
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, o);
            chk($sformatf("fetch_timeout_trap%0d", c), 32'(o), 32'(only_flt));
        end
        do_reset();
        tick(1'b0, o);
        chk("fault_cleared", 32'({o.flt, o.ill, o.rd}), 32'b001);

        // Load timeout in MEM
        do_reset();
        inst = 32'h0000A183;
        for (int c = 0; c < 3; c++) tick(1'b1, o);
        nrd = 0;
        for (int c = 0; c < TMO; c++) begin
            tick(1'b0, o);
            nrd += int'(o.rd);
        end
        chk("mem_wait_reads", 32'(nrd), 32'(TMO));
        tick(1'b0, o);
        chk("mem_timeout_trap", 32'(o), 32'(only_flt));

        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
